// File: rtl/cordic_vector_ctrl.sv
// Vectoring-mode CORDIC sequencer: iterates one rotator stage per clock and returns magnitude, angle and iteration count.
// Optional build macro CORDIC_GAIN_COMP_EN scales the returned magnitude by ~0.6074 to cancel the CORDIC gain.

module rotator (
  input  logic               enable,
  input  logic signed [16:0] x,
  input  logic signed [16:0] y,
  input  logic signed [15:0] initial_angle,
  input  logic        [2:0]  count_val,
  output logic signed [16:0] xp,
  output logic signed [16:0] yp,
  output logic signed [15:0] updated_angle,
  output logic               is_done
);
  logic signed [16:0] xs;
  logic signed [16:0] ys;
  logic signed [15:0] atan_c;

  // atan(2^-i) scaled so that 0x4000 = 45 degrees
  always_comb begin
    atan_c = 16'sd0;
    case (count_val)
      3'd0: atan_c = 16'sh4000;
      3'd1: atan_c = 16'sh25C8;
      3'd2: atan_c = 16'sh13F6;
      3'd3: atan_c = 16'sh0A22;
      3'd4: atan_c = 16'sh0516;
      3'd5: atan_c = 16'sh028C;
      3'd6: atan_c = 16'sh0146;
      3'd7: atan_c = 16'sh00A3;
      default: atan_c = 16'sd0;
    endcase
  end

  // Rotate towards the x axis: the sign of y picks the direction
  always_comb begin
    xs            = x >>> count_val;
    ys            = y >>> count_val;
    xp            = x;
    yp            = y;
    updated_angle = initial_angle;
    is_done       = 1'b0;
    if (enable) begin
      if (!y[16]) begin
        xp            = x + ys;
        yp            = y - xs;
        updated_angle = initial_angle + atan_c;
      end else begin
        xp            = x - ys;
        yp            = y + xs;
        updated_angle = initial_angle - atan_c;
      end
      is_done = (yp == 17'sd0);
    end
  end
endmodule

module cordic_vector_ctrl #(
  parameter int unsigned MAX_ITER   = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [16:0] out_mag,
  output logic signed [15:0] out_angle,
  output logic        [3:0]  out_iters,
  output logic               out_err,
  output logic               busy
);
  localparam int unsigned XW = 17;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;
  localparam logic signed [15:0] LIM = 16'sh3FFF;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t state, state_nxt;

  logic signed [XW-1:0] x_r, y_r, xp, yp, mag_c;
  logic signed [AW-1:0] ang_r, updated_angle;
  logic [CW-1:0]        cnt;
  logic                 err_r, is_done, accept, stop, in_err_c;

  assign in_ready  = (state == IDLE) | ((state == HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign busy      = (state == RUN);
  assign out_valid = (state == HOLD);
  assign stop      = ((EARLY_EXIT != 0) & is_done) | (cnt == CW'(MAX_ITER - 1));
  assign in_err_c  = x_in[15] | (x_in > LIM) | (y_in > LIM) | (y_in < -LIM);

  rotator u_rotator (
    .enable        (busy),
    .x             (x_r),
    .y             (y_r),
    .initial_angle (ang_r),
    .count_val     (cnt[2:0]),
    .xp            (xp),
    .yp            (yp),
    .updated_angle (updated_angle),
    .is_done       (is_done)
  );

`ifdef CORDIC_GAIN_COMP_EN
  // K = 2^-1 + 2^-3 - 2^-6 - 2^-9, truncating arithmetic shifts
  assign mag_c = (xp >>> 1) + (xp >>> 3) - (xp >>> 6) - (xp >>> 9);
`else
  assign mag_c = xp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (stop) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers load on accept and advance once per RUN cycle; results latch on stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r       <= '0;
      y_r       <= '0;
      ang_r     <= '0;
      cnt       <= '0;
      err_r     <= 1'b0;
      out_mag   <= '0;
      out_angle <= '0;
      out_iters <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      x_r   <= {x_in[15], x_in};
      y_r   <= {y_in[15], y_in};
      ang_r <= '0;
      cnt   <= '0;
      err_r <= in_err_c;
    end else if (state == RUN) begin
      x_r   <= xp;
      y_r   <= yp;
      ang_r <= updated_angle;
      cnt   <= cnt + CW'(1);
      if (stop) begin
        out_mag   <= mag_c;
        out_angle <= updated_angle;
        out_iters <= cnt + CW'(1);
        out_err   <= err_r;
      end
    end
  end
endmodule

// File: tb/tb_cordic_vector_ctrl.sv
// Directed bench for cordic_vector_ctrl; expected magnitudes follow CORDIC_GAIN_COMP_EN when defined.

module tb_cordic_vector_ctrl;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [16:0] out_mag;
  logic signed [15:0] out_angle;
  logic        [3:0]  out_iters;
  logic               out_err;
  logic               busy;

  int errors = 0;
  int checks = 0;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int MAG_45_1000 = 32'h1370;
  localparam int MAG_45_0800 = 32'h09B8;
  localparam int MAG_FULL    = 32'h1000;
`else
  localparam int MAG_45_1000 = 32'h2000;
  localparam int MAG_45_0800 = 32'h1000;
  localparam int MAG_FULL    = 32'h1A5A;
`endif

  cordic_vector_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mag   (out_mag),
    .out_angle (out_angle),
    .out_iters (out_iters),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y);
    x_in     = x;
    y_in     = y;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_timeout: out_valid=%b after %0d cycles", out_valid, cyc);
    end
  endtask

  task automatic retire;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL retire: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_mag !== 17'sd0 || out_iters !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b mag=%h iters=%0d required 0 0 0 0",
               out_valid, busy, out_mag, out_iters);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_early_exit;
    send(16'sh1000, 16'sh1000);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ee_run: busy=%b valid=%b required 1 0", busy, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ee_latency: valid=%b busy=%b required 1 0", out_valid, busy);
    end
    checks++;
    if (int'(out_mag) != MAG_45_1000 || out_angle !== 16'sh4000 || out_iters !== 4'd1 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL ee_result: mag=%h ang=%h iters=%0d err=%b required %h 4000 1 0",
               out_mag, out_angle, out_iters, out_err, MAG_45_1000);
    end
    retire();
  endtask

  task automatic test_full_run;
    int cyc;
    send(16'sh1000, 16'sh0000);
    // a competing vector offered during RUN must be ignored
    in_valid = 1'b1;
    x_in     = 16'sh0800;
    y_in     = 16'sh0800;
    wait_valid(cyc);
    in_valid = 1'b0;
    checks++;
    if (cyc != 8 || out_iters !== 4'd8) begin
      errors++;
      $display("FAIL full_iters: cycles=%0d iters=%0d required 8 8", cyc, out_iters);
    end
    checks++;
    if (out_angle > 16'sh00A3 || out_angle < -16'sh00A3) begin
      errors++;
      $display("FAIL full_angle: ang=%h required |ang|<=00A3", out_angle);
    end
    checks++;
    if (int'(out_mag) < MAG_FULL - 32 || int'(out_mag) > MAG_FULL + 32) begin
      errors++;
      $display("FAIL full_mag: mag=%h required %h+-20", out_mag, MAG_FULL);
    end
    retire();
  endtask

  task automatic test_back_to_back;
    send(16'sh1000, 16'sh1000);
    tick();
    in_valid = 1'b1;
    x_in     = 16'sh0800;
    y_in     = 16'sh0800;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out_mag) != MAG_45_1000 ||
          out_angle !== 16'sh4000 || out_iters !== 4'd1) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b rdy=%b mag=%h ang=%h iters=%0d required 1 0 %h 4000 1",
                 i, out_valid, in_ready, out_mag, out_angle, out_iters, MAG_45_1000);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_run: valid=%b busy=%b required 0 1", out_valid, busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || int'(out_mag) != MAG_45_0800 || out_angle !== 16'sh4000 || out_iters !== 4'd1) begin
      errors++;
      $display("FAIL b2b_result: valid=%b mag=%h ang=%h iters=%0d required 1 %h 4000 1",
               out_valid, out_mag, out_angle, out_iters, MAG_45_0800);
    end
    retire();
  endtask

  task automatic test_range_error;
    logic signed [15:0] xs [4];
    logic signed [15:0] ys [4];
    logic               ex [4];
    int                 cyc;
    xs[0] = -16'sd5;    ys[0] = 16'sh0100;  ex[0] = 1'b1;
    xs[1] = 16'sh1000;  ys[1] = 16'sh1000;  ex[1] = 1'b0;
    xs[2] = 16'sh0100;  ys[2] = -16'sh4000; ex[2] = 1'b1;
    xs[3] = 16'sh4000;  ys[3] = 16'sh0000;  ex[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(xs[i], ys[i]);
      wait_valid(cyc);
      checks++;
      if (out_err !== ex[i]) begin
        errors++;
        $display("FAIL range_err[%0d]: out_err=%b required %b", i, out_err, ex[i]);
      end
      retire();
    end
  endtask

  task automatic test_mid_run_reset;
    int seen = 0;
    send(16'sh1000, 16'sh0000);
    tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b rdy=%b required 0 0 1", busy, out_valid, in_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_no_result: active_cycles=%0d rdy=%b required 0 1", seen, in_ready);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    test_reset();
    test_early_exit();
    test_full_run();
    test_back_to_back();
    test_range_error();
    test_mid_run_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
